// File: rtl/acl_resp_pkg.sv
// Shared constants and types for the PmodACL (ADXL345) SPI responder.
// Register map, constant register values and the transaction state enum.
package acl_resp_pkg;

    localparam logic [5:0] ADDR_DEVID       = 6'h00;
    localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
    localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
    localparam logic [5:0] ADDR_DATAX0      = 6'h32;
    localparam logic [5:0] ADDR_DATAX1      = 6'h33;
    localparam logic [5:0] ADDR_DATAY0      = 6'h34;
    localparam logic [5:0] ADDR_DATAY1      = 6'h35;
    localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
    localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

    localparam logic [7:0] POWER_CTL_RST     = 8'h00;
    localparam logic [7:0] DATA_FORMAT_RST   = 8'h00;
    localparam logic [7:0] POWER_CTL_FIXED   = 8'h08;
    localparam logic [7:0] DATA_FORMAT_FIXED = 8'h00;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        DATA
    } state_t;

    // Byte 1 of an axis is the sign-extended upper two bits.
    function automatic logic [7:0] axis_byte(
        input logic [9:0] s,
        input logic       hi
    );
        return hi ? {{6{s[9]}}, s[9:8]} : s[7:0];
    endfunction

endpackage

// File: rtl/acl_spi_responder_spi_edge_sync.sv
// 2-FF synchronizer with rise/fall strobes on the synchronized level.
// Strobes are valid in the cycle after the second flop updates.
module spi_edge_sync #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstbt,
    input  logic din,
    output logic rise,
    output logic fall
);

    logic meta;
    logic sync;
    logic prev;

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            meta <= RST_VAL;
            sync <= RST_VAL;
            prev <= RST_VAL;
        end else begin
            meta <= din;
            sync <= meta;
            prev <= sync;
        end
    end

    assign rise = sync & ~prev;
    assign fall = ~sync & prev;

endmodule

// File: rtl/acl_spi_responder.sv
// SPI mode-3 responder emulating the ADXL345 register interface.
// Define ACL_RESP_WRITE_EN to make POWER_CTL and DATA_FORMAT writable.
module acl_spi_responder
    import acl_resp_pkg::*;
#(
    parameter int         SCLK_MIN_DIV = 8,
    parameter logic [7:0] DEVID_VAL    = 8'hE5
) (
    input  logic       clk,
    input  logic       rstbt,
    input  logic       sclk,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic [9:0] x_data,
    input  logic [9:0] y_data,
    input  logic [9:0] z_data,
    output logic [7:0] power_ctl,
    output logic [7:0] data_format,
    output logic       txn_done
);

    if (SCLK_MIN_DIV < 8) begin : g_div_chk
        $error("SCLK_MIN_DIV below 8 outruns the synchronizers");
    end

    logic sclk_rise, sclk_fall, ss_rise, ss_fall;
    logic mosi_meta, mosi_s;

    spi_edge_sync #(.RST_VAL(1'b1)) u_sclk (
        .clk  (clk),
        .rstbt(rstbt),
        .din  (sclk),
        .rise (sclk_rise),
        .fall (sclk_fall)
    );

    // Resetting low means a chip select held low through reset
    // never produces a fall strobe; the master must deselect first.
    spi_edge_sync #(.RST_VAL(1'b0)) u_ss (
        .clk  (clk),
        .rstbt(rstbt),
        .din  (ss_n),
        .rise (ss_rise),
        .fall (ss_fall)
    );

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            mosi_meta <= 1'b0;
            mosi_s    <= 1'b0;
        end else begin
            mosi_meta <= mosi;
            mosi_s    <= mosi_meta;
        end
    end

    state_t      state, state_nxt;
    logic [2:0]  bit_cnt;
    logic [7:0]  shift_in, shift_out;
    logic        mb, byte_seen;
    logic [5:0]  addr;
    logic [9:0]  x_snap, y_snap, z_snap;

    logic [7:0]  rx_byte;
    logic        byte_end;
    logic [5:0]  addr_nxt, load_addr;
    logic [7:0]  rd_val;

    assign rx_byte   = {shift_in[6:0], mosi_s};
    assign byte_end  = sclk_rise && (bit_cnt == 3'd7) && (state != IDLE);
    assign addr_nxt  = mb ? addr + 6'd1 : addr;
    assign load_addr = (state == CMD) ? rx_byte[5:0] : addr_nxt;

    always_comb begin
        state_nxt = state;
        if (ss_rise)
            state_nxt = IDLE;
        else if (ss_fall)
            state_nxt = CMD;
        else if (state == CMD && byte_end)
            state_nxt = DATA;
    end

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        rd_val = 8'h00;
        case (load_addr)
            ADDR_DEVID:       rd_val = DEVID_VAL;
            ADDR_POWER_CTL:   rd_val = power_ctl;
            ADDR_DATA_FORMAT: rd_val = data_format;
            ADDR_DATAX0:      rd_val = axis_byte(x_snap, 1'b0);
            ADDR_DATAX1:      rd_val = axis_byte(x_snap, 1'b1);
            ADDR_DATAY0:      rd_val = axis_byte(y_snap, 1'b0);
            ADDR_DATAY1:      rd_val = axis_byte(y_snap, 1'b1);
            ADDR_DATAZ0:      rd_val = axis_byte(z_snap, 1'b0);
            ADDR_DATAZ1:      rd_val = axis_byte(z_snap, 1'b1);
            default:          rd_val = 8'h00;
        endcase
    end

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            bit_cnt   <= '0;
            shift_in  <= '0;
            shift_out <= '0;
            mb        <= 1'b0;
            addr      <= '0;
            byte_seen <= 1'b0;
            x_snap    <= '0;
            y_snap    <= '0;
            z_snap    <= '0;
            miso      <= 1'b1;
            miso_oe   <= 1'b0;
            txn_done  <= 1'b0;
        end else begin
            txn_done <= 1'b0;
            if (ss_rise) begin
                bit_cnt   <= '0;
                miso      <= 1'b1;
                miso_oe   <= 1'b0;
                txn_done  <= byte_seen;
                byte_seen <= 1'b0;
            end else if (ss_fall) begin
                bit_cnt   <= '0;
                miso      <= 1'b1;
                miso_oe   <= 1'b1;
                byte_seen <= 1'b0;
                x_snap    <= x_data;
                y_snap    <= y_data;
                z_snap    <= z_data;
            end else if (state != IDLE) begin
                if (sclk_rise) begin
                    shift_in <= rx_byte;
                    bit_cnt  <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_seen <= 1'b1;
                        shift_out <= rd_val;
                        if (state == CMD) begin
                            mb   <= rx_byte[6];
                            addr <= rx_byte[5:0];
                        end else begin
                            addr <= addr_nxt;
                        end
                    end
                end else if (sclk_fall && state == DATA) begin
                    miso      <= shift_out[7];
                    shift_out <= {shift_out[6:0], 1'b0};
                end
            end
        end
    end

`ifdef ACL_RESP_WRITE_EN
    logic       rw;
    logic       wr_ok;
    logic [7:0] power_ctl_q, data_format_q;

    assign wr_ok = byte_end && !ss_rise && !ss_fall;

    always_ff @(posedge clk or negedge rstbt) begin
        if (!rstbt) begin
            rw            <= 1'b1;
            power_ctl_q   <= POWER_CTL_RST;
            data_format_q <= DATA_FORMAT_RST;
        end else if (wr_ok) begin
            if (state == CMD) begin
                rw <= rx_byte[7];
            end else if (!rw) begin
                case (addr)
                    ADDR_POWER_CTL:   power_ctl_q   <= rx_byte;
                    ADDR_DATA_FORMAT: data_format_q <= rx_byte;
                    default:          ;
                endcase
            end
        end
    end

    assign power_ctl   = power_ctl_q;
    assign data_format = data_format_q;
`else
    assign power_ctl   = POWER_CTL_FIXED;
    assign data_format = DATA_FORMAT_FIXED;
`endif

endmodule

// File: doc/acl_spi_responder.md
# acl_spi_responder

Synthesizable SPI mode-3 slave emulating the register interface of the PmodACL (ADXL345) accelerometer; it is the responder end of the link driven by the accelerometer SPI master. It lets the master, the rate generator and the LED display path run on the board or in simulation without the physical Pmod, serving axis samples supplied on its parallel inputs. Register reads, writes and multi-byte bursts follow the ADXL345 4-wire SPI protocol.

## Interface
- SCLK_MIN_DIV, 8, minimum `clk` cycles per SCLK period that the block must tolerate.
- DEVID_VAL, 8'hE5, value returned at address 0x00.
- clk  in  1  50 MHz system clock.
- rstbt  in  1  asynchronous, active-low reset.
- sclk  in  1  SPI clock from master; idles high (CPOL=1, CPHA=1).
- ss_n  in  1  chip select, active low.
- mosi  in  1  master-out data.
- miso  out  1  slave-out data.
- miso_oe  out  1  MISO drive enable, high only while selected.
- x_data, y_data, z_data  in  10 each  two's-complement axis samples.
- power_ctl  out  8  POWER_CTL register (0x2D).
- data_format  out  8  DATA_FORMAT register (0x31).
- txn_done  out  1  one-cycle pulse on ss_n rising edge after at least one complete byte.

## Operation
- Reset values: miso=1, miso_oe=0, power_ctl=8'h00, data_format=8'h00, txn_done=0, bit counter=0, state IDLE.
- `sclk`, `ss_n` and `mosi` pass through 2-FF synchronizers; edges are detected on the synchronized signals.
- States: IDLE -> CMD on ss_n fall. CMD -> DATA after 8 rising SCLK edges. DATA stays until ss_n rises. Any state -> IDLE on ss_n rise.
- On ss_n fall, x/y/z_data are snapshotted so a burst reads one coherent sample.
- Command byte, MSB first: bit7 R/W (1=read), bit6 MB (multi-byte), bits5:0 address.
- Read map:
  - 0x00 = DEVID_VAL.
  - 0x2D = power_ctl; 0x31 = data_format.
  - 0x32/0x33 = X0/X1, 0x34/0x35 = Y0/Y1, 0x36/0x37 = Z0/Z1.
  - Byte 0 of an axis = sample[7:0]; byte 1 = {6{sample[9]}, sample[9:8]}.
  - All other addresses read 8'h00.
- Writes: only 0x2D and 0x31 are writable. The register updates when the 8th data bit arrives. Writes to other addresses are ignored.
- After each data byte: if MB=1, the address increments, wrapping 0x3F -> 0x00. If MB=0, the address is held and the same register repeats.
- ss_n rise mid-byte: the partial byte is discarded (no write), the bit counter clears, and miso_oe falls.
- Reset mid-transaction: the block returns to IDLE and ignores SCLK until ss_n is seen high, then low again.

## Timing
- Synchronizer plus edge detect: 3 clk from a pin edge to the internal strobe.
- MOSI is sampled on the internal SCLK rising strobe.
- MISO changes on the internal SCLK falling strobe, MSB first.
- During CMD, miso=1 with miso_oe=1.
- Read data for a byte is loaded from the rising strobe of the previous byte's 8th bit, so its MSB is valid at the following falling strobe.
- miso_oe rises 3 clk after ss_n falls and drops 3 clk after ss_n rises.
- txn_done pulses in the same cycle as the ss_n rise strobe.
- Operation is correct for SCLK periods ≥ SCLK_MIN_DIV clk with high/low phases ≥ 4 clk each, i.e. ≤ 6.25 MHz at 50 MHz.

## Configuration
- ACL_RESP_WRITE_EN defined: write handling as above.
- Undefined:
  - No write logic is compiled in; every write command is ignored.
  - power_ctl is a constant 8'h08 (measure mode) and data_format a constant 8'h00; both read back those values.

## Structure
- Package acl_resp_pkg holds:
  - Register address constants (ADDR_DEVID, ADDR_POWER_CTL, ADDR_DATA_FORMAT, ADDR_DATAX0..ADDR_DATAZ1).
  - Reset/constant register values.
  - The state enum (IDLE, CMD, DATA).
- One sub-module, spi_edge_sync: 2-FF synchronizer plus rise/fall strobe generator, instantiated for sclk and ss_n; mosi uses the synchronizer only.

## Test plan
- Read 0x00 (command 8'h80) at 5 MHz SCLK -> second byte on MISO = 8'hE5; txn_done pulses once.
- x_data=10'h3F0, y_data=10'h005, z_data=10'h200; burst read command 8'hF2 for 6 bytes -> F0 FF 05 00 00 FE.
- With ACL_RESP_WRITE_EN: write 8'h08 to 0x2D (8'h2D, 8'h08) -> power_ctl=8'h08; readback 8'hAD returns 8'h08. Write to 0x32 -> no change.
- Burst read 8'hFF for 2 bytes -> 0x3F reads 00, then wraps to 0x00 reading E5. With MB=0 (8'hBF, then 8'h80 address 0 repeated for 3 bytes) -> E5 E5 E5.
- ss_n rises after 4 bits of a write data byte to 0x31 -> data_format unchanged; miso_oe low 3 clk later.
- x_data changes mid-burst -> the read bytes match the value captured at ss_n fall. Reset asserted mid-read -> all outputs return to reset values; no response until a fresh ss_n fall.
